sig_plot_writer: RTL and testbench
==================================

SIG_PLOT_WRITER -- requirements
Module: sig_plot_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h559: word address of plot sample 0.
REQ-002 SHALL have parameter DEPTH, default 320: samples per sweep.
REQ-003 SHALL have parameter MAX_CODE, default 180: display-height clamp applied to sample bits [11:4].
REQ-004 SHALL have port clock, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-006 SHALL have port enable, input, 1: level; permits arming.
REQ-007 SHALL have port trig_en, input, 1: 1 = level-crossing trigger; 0 = free-run.
REQ-008 SHALL have port trig_level, input, 12: trigger threshold, unsigned.
REQ-009 SHALL have port decim, input, 8: keep 1 of every decim+1 accepted samples.
REQ-010 SHALL have port frame_end, input, 1: one-cycle pulse at display frame end.
REQ-011 SHALL have port sample_valid, input, 1: sample_data is valid.
REQ-012 SHALL have port sample_data, input, 12: unsigned ADC sample.
REQ-013 SHALL have port sample_ready, output, 1: block accepts sample this cycle.
REQ-014 SHALL have port mem_wen, output, 1: write strobe to the signal memory.
REQ-015 SHALL have port mem_addr, output, 12: write word address.
REQ-016 SHALL have port mem_wdata, output, 32: write data.
REQ-017 SHALL have port busy, output, 1: high in ARMED or CAPTURE.
REQ-018 SHALL have port sweep_done, output, 1: one-cycle pulse when a sweep completes.

Function
REQ-019 SHALL implement states IDLE, ARMED, CAPTURE, HOLD.
REQ-020 SHALL drive sample_ready high only in ARMED and CAPTURE; a sample is accepted when sample_valid and sample_ready are both high.
REQ-021 SHALL latch decim and clear the decimation counter and the previous-kept-sample register on every entry to ARMED; decim changes at any other time are ignored.
REQ-022 SHALL mark an accepted sample as kept when the decimation counter equals the latched decim; the counter then wraps to 0, otherwise it increments.
REQ-023 SHALL, in IDLE with enable=1, go to ARMED on the next cycle.
REQ-024 SHALL, in ARMED with enable=0, go to IDLE with no write.
REQ-025 SHALL, in ARMED with trig_en=0, treat the first kept sample as the trigger.
REQ-026 SHALL, in ARMED with trig_en=1, trigger on a kept sample that is >= trig_level while the previous kept sample is < trig_level.
REQ-027 SHALL never trigger on the first kept sample after arming when trig_en=1.
REQ-028 SHALL write the trigger sample at index 0 and enter CAPTURE with index 1.
REQ-029 SHALL, in CAPTURE, write each kept sample at index idx and then increment idx.
REQ-030 SHALL ignore enable in CAPTURE; a sweep always completes.
REQ-031 SHALL, after the write at index DEPTH-1, enter HOLD and pulse sweep_done in the same cycle as that write's mem_wen.
REQ-032 SHALL, in HOLD on frame_end, go to ARMED if enable=1 and to IDLE otherwise.
REQ-033 SHALL ignore a frame_end that coincides with the final write; that frame_end does not release HOLD.
REQ-034 SHALL register write outputs so that mem_wen pulses exactly 1 cycle after the kept accept, with mem_addr = BASE_ADDR + idx (12-bit, modulo 4096).
REQ-035 SHALL format mem_wdata as {20'b0, sample_data} when sample_data[11:4] <= MAX_CODE, else {20'b0, MAX_CODE[7:0], 4'h0}.
REQ-036 SHALL compare the trigger using the unclamped sample.
REQ-037 SHALL hold mem_addr and mem_wdata at their last values when mem_wen=0.

Reset
REQ-038 SHALL, while reset is high, force state IDLE, idx 0, decimation counter 0, and outputs sample_ready, mem_wen, busy, sweep_done, mem_addr and mem_wdata all 0, asynchronously.
REQ-039 SHALL, on reset asserted mid-CAPTURE, abandon the sweep without completing it and restart from IDLE after reset release.

Verification
REQ-040 SHALL cover free-run: enable=1, trig_en=0, decim=0, samples 0..319 every cycle -> 320 writes to addresses 0x559..0x698 with data = sample; sweep_done coincides with the write to 0x698; busy low afterwards.
REQ-041 SHALL cover the trigger: trig_en=1, trig_level=0x800, ramp 0x700,0x7F0,0x810 -> the first write is 0x810 at 0x559 and nothing is written before it.
REQ-042 SHALL cover decimation: decim=3, 8 accepted samples 0..7 in free-run -> writes 3 and 7 only, at 0x559 and 0x55A.
REQ-043 SHALL cover the clamp: sample 0xC35 -> mem_wdata = 0x00000B40; sample 0xB4F -> mem_wdata = 0x00000B4F.
REQ-044 SHALL cover HOLD release: after sweep_done, frame_end with enable=0 -> IDLE, sample_ready=0; with enable=1 -> ARMED, sample_ready=1 the next cycle.
REQ-045 SHALL cover reset at idx=100 -> all outputs 0 immediately; after release with enable=1, the next sweep starts at 0x559.

Source files
------------

// File: rtl/sig_plot_writer.sv
// Oscilloscope-style sweep writer: decimates an ADC stream, waits for a trigger,
// then writes one sweep of clamped samples into the display signal memory.
module sig_plot_writer #(
  parameter logic [11:0] BASE_ADDR = 12'h559,
  parameter int          DEPTH     = 320,
  parameter int          MAX_CODE  = 180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        trig_en,
  input  logic [11:0] trig_level,
  input  logic [7:0]  decim,
  input  logic        frame_end,
  input  logic        sample_valid,
  input  logic [11:0] sample_data,
  output logic        sample_ready,
  output logic        mem_wen,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        sweep_done
);

  localparam int             IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0]  LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [7:0]     MAX_CODE8 = 8'(MAX_CODE);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      dec_cnt_q, dec_cnt_d;
  logic [7:0]      decim_q, decim_d;
  logic [11:0]     prev_q, prev_d;
  logic            prev_valid_q, prev_valid_d;
  logic            mem_wen_q, mem_wen_d;
  logic [11:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            sweep_done_q, sweep_done_d;

  logic            accept, kept, crossing, trig_hit, write_fire, is_last, arm_entry;
  logic [IW-1:0]   write_idx;

  assign accept    = sample_valid && sample_ready;
  assign kept      = accept && (dec_cnt_q == decim_q);
  // Trigger looks at the raw sample, never the display-clamped value.
  assign crossing  = prev_valid_q && (prev_q < trig_level) && (sample_data >= trig_level);
  assign trig_hit  = kept && (!trig_en || crossing);
  assign write_idx = (state_q == ARMED) ? '0 : idx_q;
  assign is_last   = (write_idx == LAST_IDX);
  assign write_fire = ((state_q == ARMED) && enable && trig_hit) ||
                      ((state_q == CAPTURE) && kept);
  assign arm_entry = (state_d == ARMED) && (state_q != ARMED);

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // logic lives in always_comb so each flop has exactly one clocked writer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = ARMED;
      ARMED: begin
        if (!enable)        state_d = IDLE;
        else if (trig_hit)  state_d = is_last ? HOLD : CAPTURE;
      end
      CAPTURE: if (kept && is_last) state_d = HOLD;
      // The frame_end arriving alongside the final write belongs to the old sweep.
      HOLD:    if (frame_end && !sweep_done_q) state_d = enable ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_ready = (state_q == ARMED) || (state_q == CAPTURE);
    busy         = (state_q == ARMED) || (state_q == CAPTURE);
  end

  // NOTE: every variable gets its default at the top of the block, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    idx_d        = idx_q;
    dec_cnt_d    = dec_cnt_q;
    decim_d      = decim_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    mem_wen_d    = write_fire;
    sweep_done_d = write_fire && is_last;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (arm_entry) begin
      decim_d      = decim;
      dec_cnt_d    = '0;
      prev_d       = '0;
      prev_valid_d = 1'b0;
      idx_d        = '0;
    end else begin
      if (accept) dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
      if (kept) begin
        prev_d       = sample_data;
        prev_valid_d = 1'b1;
      end
      if (write_fire) idx_d = write_idx + IW'(1);
    end

    if (write_fire) begin
      mem_addr_d = BASE_ADDR + 12'(write_idx);
      if (sample_data[11:4] > MAX_CODE8) mem_wdata_d = {20'b0, MAX_CODE8, 4'h0};
      else                               mem_wdata_d = {20'b0, sample_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      dec_cnt_q    <= '0;
      decim_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      dec_cnt_q    <= dec_cnt_d;
      decim_q      <= decim_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_sig_plot_writer.sv
// Self-checking bench for sig_plot_writer: expected writes go to a scoreboard
// queue as stimulus is driven; a negedge monitor pops and compares each write.
module tb_sig_plot_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        trig_en;
  logic [11:0] trig_level;
  logic [7:0]  decim;
  logic        frame_end;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        sample_ready;
  logic        mem_wen;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        sweep_done;

  sig_plot_writer dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .trig_en      (trig_en),
    .trig_level   (trig_level),
    .decim        (decim),
    .frame_end    (frame_end),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .sweep_done   (sweep_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  typedef struct {
    logic [11:0] sample;
    logic [31:0] exp_wdata;
  } vec_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  checks      = 0;
  int  failures    = 0;
  int  write_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [11:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d, input logic done);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.done = done;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    sample_valid = 1'b0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    check("sb_drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    enable       = 1'b0;
    frame_end    = 1'b0;
    sample_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic arm(input logic [7:0] d, input logic te, input logic [11:0] lvl);
    decim      = d;
    trig_en    = te;
    trig_level = lvl;
    enable     = 1'b1;
    tick();
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_wen) begin
        write_count++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%h data=%h required=no write", mem_addr, mem_wdata);
        end else begin
          mon_e = sb_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("wr_data", mem_wdata, mon_e.data);
          check("wr_sweep_done", 32'(sweep_done), 32'(mon_e.done));
        end
      end else if (sweep_done) begin
        checks++;
        failures++;
        $display("FAIL sweep_done_without_write actual=1 required=0");
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{12'hC35, 32'h0000_0B40};
    vecs[1] = '{12'hB4F, 32'h0000_0B4F};
    vecs[2] = '{12'hB50, 32'h0000_0B40};
    vecs[3] = '{12'h000, 32'h0000_0000};
    vecs[4] = '{12'hFFF, 32'h0000_0B40};
    vecs[5] = '{12'hB40, 32'h0000_0B40};
    vecs[6] = '{12'hB3F, 32'h0000_0B3F};

    reset = 1'b1; enable = 1'b0; trig_en = 1'b0; trig_level = '0; decim = '0;
    frame_end = 1'b0; sample_valid = 1'b0; sample_data = '0;
    tick();
    check("rst_sample_ready", 32'(sample_ready), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_stays_idle", 32'(sample_ready), 32'd0);

    // Free-run full sweep.
    arm(8'd0, 1'b0, 12'h000);
    check("armed_ready", 32'(sample_ready), 32'd1);
    check("armed_busy", 32'(busy), 32'd1);
    write_count = 0;
    for (int i = 0; i < 320; i++) begin
      push(12'h559 + 12'(i), 32'(i), i == 319);
      send(12'(i));
    end
    sample_valid = 1'b0;
    check("hold_ready_low", 32'(sample_ready), 32'd0);
    check("hold_busy_low", 32'(busy), 32'd0);
    drain(4);
    check("sweep_write_count", 32'(write_count), 32'd320);

    // HOLD release with enable low goes to IDLE; re-enable proves it left HOLD.
    enable = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("hold_rel_idle_ready", 32'(sample_ready), 32'd0);
    check("hold_rel_idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    check("idle_to_armed_ready", 32'(sample_ready), 32'd1);

    // ARMED with enable dropped: back to IDLE with no write.
    enable = 1'b0;
    send(12'h555);
    sample_valid = 1'b0;
    check("armed_disable_ready", 32'(sample_ready), 32'd0);
    check("armed_disable_busy", 32'(busy), 32'd0);
    drain(3);

    // Clamp table in free-run.
    do_reset();
    arm(8'd0, 1'b0, 12'h000);
    for (int i = 0; i < 7; i++) begin
      push(12'h559 + 12'(i), vecs[i].exp_wdata, 1'b0);
      send(vecs[i].sample);
      check("tbl_wen", 32'(mem_wen), 32'd1);
      check("tbl_wdata", mem_wdata, vecs[i].exp_wdata);
    end
    drain(3);

    // Trigger on the raw sample, even though its clamped value is below level.
    do_reset();
    arm(8'd0, 1'b1, 12'hC00);
    push(12'h559, 32'h0000_0B40, 1'b0);
    send(12'hB00);
    send(12'hC35);
    drain(3);

    // Ramp crossing, then the next kept sample lands at index 1.
    do_reset();
    arm(8'd0, 1'b1, 12'h800);
    push(12'h559, 32'h0000_0810, 1'b0);
    send(12'h700);
    send(12'h7F0);
    send(12'h810);
    push(12'h55A, 32'h0000_0000, 1'b0);
    send(12'h000);
    drain(3);

    // First kept sample above level never triggers; equality counts as a crossing.
    do_reset();
    arm(8'd0, 1'b1, 12'h800);
    push(12'h559, 32'h0000_0800, 1'b0);
    send(12'h900);
    send(12'h950);
    send(12'h100);
    send(12'h800);
    drain(3);

    // Decimation by 4; decim changes after arming are ignored.
    do_reset();
    arm(8'd3, 1'b0, 12'h000);
    decim = 8'd0;
    push(12'h559, 32'd3, 1'b0);
    push(12'h55A, 32'd7, 1'b0);
    for (int i = 0; i < 8; i++) send(12'(i));
    drain(3);

    // frame_end coinciding with the final write is ignored; next one re-arms.
    do_reset();
    arm(8'd0, 1'b0, 12'h000);
    for (int i = 0; i < 320; i++) begin
      push(12'h559 + 12'(i), 32'(i), i == 319);
      send(12'(i));
    end
    sample_valid = 1'b0;
    check("final_write_wen", 32'(mem_wen), 32'd1);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("hold_ignores_fe", 32'(sample_ready), 32'd0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("hold_rearm_ready", 32'(sample_ready), 32'd1);
    check("hold_rearm_busy", 32'(busy), 32'd1);
    push(12'h559, 32'h0000_0ABC, 1'b0);
    send(12'hABC);
    drain(3);

    // Reset asserted mid-capture at idx=100.
    do_reset();
    arm(8'd0, 1'b0, 12'h000);
    for (int i = 0; i < 100; i++) begin
      push(12'h559 + 12'(i), 32'h200 + 32'(i), 1'b0);
      send(12'h200 + 12'(i));
    end
    sample_valid = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("midrst_sample_ready", 32'(sample_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_wen", 32'(mem_wen), 32'd0);
    check("midrst_sweep_done", 32'(sweep_done), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    check("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();
    reset = 1'b0;
    arm(8'd0, 1'b0, 12'h000);
    push(12'h559, 32'h0000_0321, 1'b0);
    send(12'h321);
    drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
